ps2_rx_ctrl: RTL and testbench
==============================

Name: ps2_rx_ctrl

Overview:
System-clock PS/2 receive controller for the wb_ps2 peripheral. It synchronises and filters the PS/2 clock and data lines, then sequences frame capture with an explicit FSM: start, 8 data bits, odd parity, stop. It resolves E0/F0 prefixes into make/break scan-code entries and buffers them in a small FIFO popped by the Wishbone wrapper. Framing, parity and timeout errors and overflow are reported as sticky flags.

Parameters:
TIMEOUT_CYCLES, 50000, clk_i cycles with no PS/2 falling edge before an in-progress frame is aborted (1 ms at 50 MHz)
FILTER_LEN, 4, consecutive identical synchronised samples required before the filtered PS/2 clock changes (range 2..15)
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW

Ports:
clk_i  in  1  system clock; all logic is in this domain
rst_n_i  in  1  asynchronous active-low reset
ps2_clk_i  in  1  raw PS/2 clock line (asynchronous)
ps2_data_i  in  1  raw PS/2 data line (asynchronous)
pop_i  in  1  pop FIFO head; ignored when valid_o=0
code_o  out  8  scan code at FIFO head
brk_o  out  1  head entry is a break (F0-prefixed)
ext_o  out  1  head entry is extended (E0-prefixed)
valid_o  out  1  FIFO not empty
count_o  out  FIFO_AW+1  FIFO occupancy
err_parity_o  out  1  sticky parity error
err_frame_o  out  1  sticky start/stop/timeout error
ovf_o  out  1  sticky overflow (entry dropped)
err_clr_i  in  1  clears all three sticky flags

Behaviour:
- Reset (async, rst_n_i=0): FSM=IDLE, FIFO empty, count_o=0, valid_o=0, code_o/brk_o/ext_o=0, all sticky flags=0, prefix flags=0, filtered clock=1, timeout counter=0.
- Input path: 2-flop synchroniser on each line. Filtered clock changes only after FILTER_LEN equal consecutive samples. A 1->0 transition of the filtered clock is a sample event; the synchronised data bit is captured on that cycle.
- FSM, one transition per sample event:
  - IDLE: data=0 -> DATA with bit counter=0; data=1 -> stay in IDLE (spurious event, no error).
  - DATA: shift data in LSB first; after bit 7 -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: data=1 and odd parity over 9 bits -> byte accepted; else discard. Return to IDLE in all cases.
- Error flags:
  - Stop=0 sets err_frame_o; parity error (stop=1) sets err_parity_o. If both fail, only err_frame_o is set.
  - Timeout counter clears on every sample event and counts only outside IDLE. On reaching TIMEOUT_CYCLES-1, the frame is aborted: IDLE, err_frame_o set.
  - Any error or abort clears both prefix flags.
- Decode, on the cycle after acceptance:
  - 0xE0 sets ext flag; 0xF0 sets brk flag; neither is pushed.
  - Any other byte pushes {ext,brk,byte}, then clears both flags.
  - The pushed entry is visible on the outputs 2 cycles after the STOP sample event if the FIFO was empty.
- FIFO:
  - First-word-fall-through; code_o/brk_o/ext_o show the head when valid_o=1 and hold the last value when empty.
  - Pointers wrap modulo 2**FIFO_AW; count_o distinguishes full from empty.
  - Push when full with no pop: entry dropped, ovf_o set.
  - Push and pop in the same cycle: both succeed, count unchanged (including when full).
  - Pop when empty: no effect.
- Sticky flags: set has priority over err_clr_i in the same cycle.
- Reset mid-frame: partial frame and prefixes are discarded. The next valid start bit after reset is received normally.

Optional Feature:
Macro PS2_INHIBIT_EN.
- Defined: adds output ps2_clk_oe_o (1 = drive the PS/2 clock low via an external open-drain buffer). Asserted once count_o reaches depth-1 and the FSM is in IDLE, so the device holds further bytes and no overflow occurs. Released when count_o drops below depth-1. Never asserted mid-frame. Reset value 0.
- Not defined: port absent; overflow handled by drop + ovf_o only.

Test Plan:
- Frame 0x1C, correct parity and stop -> valid_o=1, code_o=0x1C, brk_o=0, ext_o=0, count_o=1. Pop -> valid_o=0.
- Frames F0 then 1C -> single entry {ext=0,brk=1,code=0x1C}, count_o=1. Frames E0,F0,75 -> {1,1,0x75}.
- Frame 0x1C with parity bit inverted -> err_parity_o=1, count_o=0. Following E0 then frame 0x74 with stop=0 -> err_frame_o=1, prefix cleared. Next frame 0x74 -> {0,0,0x74}. err_clr_i -> flags=0.
- Five data bits then silence for TIMEOUT_CYCLES -> err_frame_o=1, FSM back in IDLE. Next full frame 0x29 -> accepted.
- Six codes 0x01..0x06 with no pop (FIFO_AW=2) -> count_o=4, ovf_o=1. Pops return 0x01..0x04. Pop and push in the same cycle at full -> count_o stays 4.
- Single-cycle glitches on ps2_clk_i shorter than FILTER_LEN -> no sample event. With PS2_INHIBIT_EN defined: ps2_clk_oe_o=1 at count_o=3 and 0 after one pop.

Source files
------------

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: synchronise/filter the PS/2 lines, capture 11-bit frames,
// resolve E0/F0 prefixes and buffer make/break entries in a FWFT FIFO. Optional PS2_INHIBIT_EN.
module ps2_rx_ctrl #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN     = 4,
    parameter int FIFO_AW        = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               ps2_clk_i,
    input  logic               ps2_data_i,
    input  logic               pop_i,
    output logic [7:0]         code_o,
    output logic               brk_o,
    output logic               ext_o,
    output logic               valid_o,
    output logic [FIFO_AW:0]   count_o,
    output logic               err_parity_o,
    output logic               err_frame_o,
    output logic               ovf_o,
    input  logic               err_clr_i
`ifdef PS2_INHIBIT_EN
    ,
    output logic               ps2_clk_oe_o
`endif
);

    localparam int                 DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW + 1)'(DEPTH);
    localparam int                 TW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]      TO_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         FLT_MAX = 4'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } entry_t;

    // ------------------------------------------------------------------
    // Input synchronisers and clock glitch filter
    // ------------------------------------------------------------------
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_s;
    logic       data_s;
    logic       clk_filt_q;
    logic [3:0] flt_cnt_q;
    logic       flt_flip;
    logic       sample_evt;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    assign flt_flip   = (clk_s != clk_filt_q) && (flt_cnt_q == FLT_MAX);
    assign sample_evt = flt_flip && clk_filt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_filt_q <= 1'b1;
            flt_cnt_q  <= '0;
        end else if (clk_s == clk_filt_q) begin
            flt_cnt_q  <= '0;
        end else if (flt_flip) begin
            clk_filt_q <= ~clk_filt_q;
            flt_cnt_q  <= '0;
        end else begin
            flt_cnt_q  <= flt_cnt_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q;
    logic          timeout_hit;
    logic          accept_d, accept_q;
    logic [7:0]    byte_q;
    logic          set_frame;
    logic          set_parity;

    assign timeout_hit = (state_q != S_IDLE) && !sample_evt && (to_cnt_q == TO_MAX);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        accept_d   = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
        if (timeout_hit) begin
            state_d   = S_IDLE;
            set_frame = 1'b1;
        end else if (sample_evt) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = data_s;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!data_s)                  set_frame  = 1'b1;
                    else if (!(^{shift_q, par_q})) set_parity = 1'b1;
                    else                          accept_d   = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            accept_q  <= 1'b0;
            byte_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            accept_q  <= accept_d;
            if (accept_d) byte_q <= shift_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                             to_cnt_q <= '0;
        else if (state_q == S_IDLE || sample_evt) to_cnt_q <= '0;
        else if (timeout_hit)                     to_cnt_q <= '0;
        else                                      to_cnt_q <= to_cnt_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Prefix decode
    // ------------------------------------------------------------------
    logic   ext_q, brk_q;
    logic   push_req;
    entry_t push_entry;

    assign push_req   = accept_q && (byte_q != 8'hE0) && (byte_q != 8'hF0);
    assign push_entry = '{ext: ext_q, brk: brk_q, code: byte_q};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (set_frame || set_parity) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (accept_q) begin
            if (byte_q == 8'hE0) begin
                ext_q <= 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    entry_t             mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    entry_t             last_q;
    entry_t             head;
    logic               full;
    logic               pop_en;
    logic               push_en;
    logic               ovf_set;

    assign full    = (count_q == DEPTH_C);
    assign valid_o = (count_q != '0);
    assign pop_en  = pop_i && valid_o;
    assign push_en = push_req && (!full || pop_en);
    assign ovf_set = push_req && full && !pop_en;

    // NOTE: storage array has no reset; the valid-gated output mux keeps its contents invisible until written.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Once drained, the outputs keep showing the last entry popped.
    assign head    = valid_o ? mem_q[rd_ptr_q] : last_q;
    assign code_o  = head.code;
    assign brk_o   = head.brk;
    assign ext_o   = head.ext;
    assign count_o = count_q;

    // ------------------------------------------------------------------
    // Sticky error flags: set wins over clear
    // ------------------------------------------------------------------
    logic err_par_q, err_frm_q, ovf_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_par_q <= 1'b0;
            err_frm_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (set_parity)     err_par_q <= 1'b1;
            else if (err_clr_i) err_par_q <= 1'b0;
            if (set_frame)      err_frm_q <= 1'b1;
            else if (err_clr_i) err_frm_q <= 1'b0;
            if (ovf_set)        ovf_q     <= 1'b1;
            else if (err_clr_i) ovf_q     <= 1'b0;
        end
    end

    assign err_parity_o = err_par_q;
    assign err_frame_o  = err_frm_q;
    assign ovf_o        = ovf_q;

`ifdef PS2_INHIBIT_EN
    localparam logic [FIFO_AW:0] INHIBIT_LVL = DEPTH_C - 1'b1;

    logic clk_oe_q;

    // Only start holding the clock between frames so a byte is never cut short.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                     clk_oe_q <= 1'b0;
        else if (count_q < INHIBIT_LVL)   clk_oe_q <= 1'b0;
        else if (state_q == S_IDLE)       clk_oe_q <= 1'b1;
    end

    assign ps2_clk_oe_o = clk_oe_q;
`endif

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: table-driven frames plus hand-written corner sequences,
// with a scoreboard queue of expected FIFO entries. Honours PS2_INHIBIT_EN when defined.
module tb_ps2_rx_ctrl;

    localparam int TO    = 400;
    localparam int FL    = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int HALF  = 10;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          ps2_clk  = 1'b1;
    logic          ps2_data = 1'b1;
    logic          pop      = 1'b0;
    logic          err_clr  = 1'b0;
    logic [7:0]    code_o;
    logic          brk, ext, valid;
    logic [AW:0]   count_o;
    logic          err_par, err_frm, ovf;
`ifdef PS2_INHIBIT_EN
    logic          clk_oe;
`endif

    always #5 clk = ~clk;

    ps2_rx_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FL),
        .FIFO_AW       (AW)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .pop_i        (pop),
        .code_o       (code_o),
        .brk_o        (brk),
        .ext_o        (ext),
        .valid_o      (valid),
        .count_o      (count_o),
        .err_parity_o (err_par),
        .err_frame_o  (err_frm),
        .ovf_o        (ovf),
        .err_clr_i    (err_clr)
`ifdef PS2_INHIBIT_EN
        ,
        .ps2_clk_oe_o (clk_oe)
`endif
    );

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        bit         clr;
        bit         drain;
        int         exp_count;
        bit         exp_par;
        bit         exp_frm;
    } vec_t;

    vec_t       vecs [14];
    logic [9:0] exp_q [$];
    logic       m_ext, m_brk, m_par, m_frm, m_ovf;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ext = 0; m_brk = 0; m_par = 0; m_frm = 0; m_ovf = 0;
    endtask

    task automatic model_frame(input logic [7:0] c, input bit bp, input bit bs);
        if (bs) begin
            m_frm = 1; m_ext = 0; m_brk = 0;
        end else if (bp) begin
            m_par = 1; m_ext = 0; m_brk = 0;
        end else if (c == 8'hE0) begin
            m_ext = 1;
        end else if (c == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, c});
            else                      m_ovf = 1;
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Drives nbits of an 11-bit frame; with pop_at_push, pulses pop in the push cycle of the stop bit.
    task automatic send_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit pop_at_push);
        logic [10:0] bits;
        int          min_cnt;
        bits = {~bad_stop, (~^c) ^ bad_par, c, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            idle(HALF);
            if (pop_at_push && i == 10) begin
                check("head_before_pushpop", {ext, brk, code_o}, exp_q[0]);
                void'(exp_q.pop_front());
                ps2_clk = 1'b0;
                min_cnt = DEPTH;
                for (int k = 0; k < HALF; k++) begin
                    @(negedge clk);
                    if (int'(count_o) < min_cnt) min_cnt = int'(count_o);
                    if (k == 5) pop = 1'b1;
                    if (k == 6) pop = 1'b0;
                end
                check("count_min_pushpop", min_cnt, DEPTH);
            end else begin
                ps2_clk = 1'b0;
                idle(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        idle(2 * HALF + 10);
        if (nbits == 11) model_frame(c, bad_par, bad_stop);
    endtask

    task automatic send(input logic [7:0] c);
        send_frame(c, 1'b0, 1'b0, 11, 1'b0);
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_par = 0; m_frm = 0; m_ovf = 0;
        idle(1);
    endtask

    task automatic pop_one();
        check("pop_valid", valid, 1'b1);
        check("pop_head", {ext, brk, code_o}, exp_q[0]);
        void'(exp_q.pop_front());
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) pop_one();
        check("drain_valid", valid, 1'b0);
        check("drain_count", count_o, 0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_par"}, err_par, m_par);
        check({tag, "_frm"}, err_frm, m_frm);
        check({tag, "_ovf"}, ovf, m_ovf);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //               code  par stop clr drn cnt par frm
        vecs[0]  = '{8'h1C, 0, 0, 0, 1, 1, 0, 0};
        vecs[1]  = '{8'hF0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{8'h1C, 0, 0, 0, 1, 1, 0, 0};
        vecs[3]  = '{8'hE0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{8'hF0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{8'h75, 0, 0, 0, 1, 1, 0, 0};
        vecs[6]  = '{8'h1C, 1, 0, 0, 0, 0, 1, 0};
        vecs[7]  = '{8'hE0, 0, 0, 0, 0, 0, 1, 0};
        vecs[8]  = '{8'h74, 0, 1, 0, 0, 0, 1, 1};
        vecs[9]  = '{8'h74, 0, 0, 1, 1, 1, 1, 1};
        vecs[10] = '{8'h33, 1, 1, 1, 0, 0, 0, 1};
        vecs[11] = '{8'hE0, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{8'h6B, 1, 0, 1, 0, 0, 1, 0};
        vecs[13] = '{8'h6B, 0, 0, 0, 1, 1, 0, 0};

        model_reset();
        idle(3);
        check("rst_valid", valid, 1'b0);
        check("rst_count", count_o, 0);
        check("rst_head", {ext, brk, code_o}, 10'h000);
        check("rst_flags", {err_par, err_frm, ovf}, 3'b000);
`ifdef PS2_INHIBIT_EN
        check("rst_clk_oe", clk_oe, 1'b0);
`endif
        rst_n = 1'b1;
        idle(5);

        // Table-driven frames: prefixes, parity/stop errors, flag clearing.
        for (int i = 0; i < 14; i++) begin
            send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, 11, 1'b0);
            check($sformatf("vec%0d_count", i), count_o, vecs[i].exp_count);
            check($sformatf("vec%0d_par", i), err_par, vecs[i].exp_par);
            check($sformatf("vec%0d_frm", i), err_frm, vecs[i].exp_frm);
            if (vecs[i].clr) begin
                clear_flags();
                check($sformatf("vec%0d_clr", i), {err_par, err_frm}, 2'b00);
            end
            if (vecs[i].drain) drain();
        end

        // Spurious high-data clock fall in IDLE, then sub-filter glitches with data low.
        ps2_data = 1'b1;
        idle(HALF); ps2_clk = 1'b0; idle(HALF); ps2_clk = 1'b1; idle(HALF);
        ps2_data = 1'b0;
        for (int k = 1; k < FL; k++) begin
            ps2_clk = 1'b0; idle(k); ps2_clk = 1'b1; idle(8);
        end
        ps2_data = 1'b1;
        idle(HALF);
        send(8'h5A);
        check("glitch_count", count_o, 1);
        check_flags("glitch");
        drain();

        // Timeout mid-frame after an E0 prefix; prefix must be dropped.
        send(8'hE0);
        send_frame(8'hFF, 1'b0, 1'b0, 6, 1'b0);
        idle(TO + 50);
        m_frm = 1; m_ext = 0; m_brk = 0;
        check("timeout_frm", err_frm, 1'b1);
        check("timeout_count", count_o, 0);
        send(8'h29);
        check("after_timeout_count", count_o, 1);
        check_flags("after_timeout");
        drain();
        clear_flags();

        // Reset in the middle of a prefixed frame.
        send(8'hE0);
        send_frame(8'h12, 1'b0, 1'b0, 4, 1'b0);
        rst_n = 1'b0;
        idle(3);
        check("midrst_valid", valid, 1'b0);
        rst_n = 1'b1;
        model_reset();
        idle(5);
        send(8'h3C);
        check("midrst_count", count_o, 1);
        check_flags("midrst");
        drain();

        // Overflow: six codes into a four-deep FIFO.
        for (int c = 1; c <= 6; c++) send(8'(c));
        check("ovf_count", count_o, DEPTH);
        check("ovf_flag", ovf, 1'b1);
        check_flags("ovf");
        drain();
        clear_flags();

        // Simultaneous push and pop while full.
        for (int c = 7; c <= 10; c++) send(8'(c));
        check("refill_count", count_o, DEPTH);
        send_frame(8'h0B, 1'b0, 1'b0, 11, 1'b1);
        check("pushpop_count", count_o, DEPTH);
        check("pushpop_ovf", ovf, 1'b0);
        drain();

`ifdef PS2_INHIBIT_EN
        for (int c = 8'h11; c <= 8'h13; c++) send(8'(c));
        check("inhibit_count", count_o, DEPTH - 1);
        check("inhibit_on", clk_oe, 1'b1);
        pop_one();
        idle(2);
        check("inhibit_off", clk_oe, 1'b0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
